// File: rtl/rr_fanout_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : rr_fanout_pkg                                                    |
// | Brief   : Shared types, default sizes and the rotate-index helper used by  |
// |           the round-robin fanout arbiter and its priority picker.          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package rr_fanout_pkg;

  // Arbiter FSM states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Default instance sizes.
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);

  // (base + off) mod n, for base < n and off < n; avoids a real divider.
  function automatic int unsigned rot_idx(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    if (s >= n) begin
      s = s - n;
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_fanout_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : rr_fanout_if                                                   |
// | Brief     : Requester-side and load-tree-side signals of the fanout        |
// |             arbiter. 'master' is the side that drives the requests and    |
// |             accepts output beats; 'slave' is the arbiter itself.          |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface rr_fanout_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4
);
  localparam int GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic                      out_ready;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;

  modport master (
    output req_valid, req_len, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_last, grant_id, busy
  );

  modport slave (
    input  req_valid, req_len, req_data, out_ready,
    output req_ready, out_valid, out_data, out_last, grant_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_fanout_arbiter_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_pick                                                           |
// | Brief  : Combinational rotate-priority encoder. Returns the first set     |
// |          request bit at or after ptr_i, wrapping past NUM_REQ-1 to 0.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module rr_pick
  import rr_fanout_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] req_i,
  input  wire logic [PTR_W-1:0]   ptr_i,
  output logic                    any_o,
  output logic [PTR_W-1:0]        idx_o
);

  int unsigned      w_cand;
  logic [PTR_W-1:0] w_cand_idx;

  // Walk offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
  always_comb begin
    any_o      = 1'b0;
    idx_o      = '0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand     = rot_idx(32'(ptr_i), k, NUM_REQ);
      w_cand_idx = PTR_W'(w_cand);
      if (!any_o && req_i[w_cand_idx]) begin
        any_o = 1'b1;
        idx_o = w_cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_fanout_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_fanout_arbiter                                                 |
// | Brief  : Grants one requester at a time a burst of req_len+1 beats on a    |
// |          shared high-fanout driver, round-robin between bursts. Every     |
// |          beat goes through one output register (the repeater).           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module rr_fanout_arbiter
  import rr_fanout_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  wire logic   clk,
  input  wire logic   rst,
  rr_fanout_if.slave  bus_io
);

  localparam int GID_W = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [GID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]    grant_q, grant_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic [LEN_W-1:0]    w_len  [NUM_REQ];
  logic [DATA_W-1:0]   w_data [NUM_REQ];
  logic                w_any;
  logic [GID_W-1:0]    w_pick;
  logic                w_owner_rdy;
  logic                w_fire;
  logic [NUM_REQ-1:0]  w_ready;

  // Split the packed per-requester buses into indexable arrays.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_len[i]  = bus_io.req_len[i*LEN_W +: LEN_W];
    assign w_data[i] = bus_io.req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (GID_W)
  ) u_pick (
    .req_i   (bus_io.req_valid),
    .ptr_i   (rr_ptr_q),
    .any_o   (w_any),
    .idx_o   (w_pick)
  );

  // The output stage is one deep with no skid: it can take a beat only when
  // empty or draining this cycle.
  assign w_owner_rdy = !out_valid_q || bus_io.out_ready;
  assign w_fire      = (state_q == BURST) && bus_io.req_valid[grant_q] && w_owner_rdy;

  // Only the current owner ever sees ready, and only during a burst.
  always_comb begin
    w_ready = '0;
    if (state_q == BURST) begin
      w_ready[grant_q] = w_owner_rdy;
    end
  end

  // Arbitration, burst counting and output-register next state.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    case (state_q)
      IDLE: begin
        if (w_any) begin
          grant_d = w_pick;
          cnt_d   = w_len[w_pick];
          state_d = BURST;
        end
      end
      BURST: begin
        if (w_fire) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            // Pointer moves past the finishing owner; the next grant is
            // decided in the following IDLE cycle.
            rr_ptr_d = GID_W'(rot_idx(32'(grant_q), 1, NUM_REQ));
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Repeater register: load on a beat, otherwise drain when accepted.
    if (w_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = w_data[grant_q];
      out_last_d  = (cnt_q == '0);
    end else if (bus_io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus_io.req_ready = w_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_last  = out_last_q;
  assign bus_io.grant_id  = grant_q;
  assign bus_io.busy      = (state_q == BURST);

endmodule
`default_nettype wire
